// File: rtl/ahmes_mem_ctrl_if.sv
// Ahmes memory-port bundle: CPU request/response bus plus the boot-loader byte stream.
// The master side is the CPU control unit together with the board-level program source.
interface ahmes_mem_ctrl_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
);
   logic [ADDR_W-1:0] address_bus;
   logic [DATA_W-1:0] data_out;
   logic              mem_re;
   logic              mem_we;
   logic [DATA_W-1:0] data_bus;
   logic [DATA_W-1:0] instr_bus;
   logic              boot_start;
   logic              boot_valid;
   logic [DATA_W-1:0] boot_data;
   logic              boot_last;
   logic              boot_ready;
   logic [ADDR_W-1:0] boot_addr;
   logic              boot_done;
   logic              cpu_hold;

   modport master (
      output address_bus, data_out, mem_re, mem_we,
      output boot_start, boot_valid, boot_data, boot_last,
      input  data_bus, instr_bus, boot_ready, boot_addr, boot_done, cpu_hold
   );

   modport slave (
      input  address_bus, data_out, mem_re, mem_we,
      input  boot_start, boot_valid, boot_data, boot_last,
      output data_bus, instr_bus, boot_ready, boot_addr, boot_done, cpu_hold
   );
endinterface

// File: rtl/ahmes_mem_ctrl.sv
// Ahmes CPU memory: 256x8 synchronous RAM with read-first CPU port and a boot loader
// that streams a program image from address 0 while holding the CPU.
module ahmes_mem_ctrl #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8,
   parameter int DEPTH  = 256
) (
   input  logic            clk,
   input  logic            reset,
   ahmes_mem_ctrl_if.slave mem_if
);

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      BOOT = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e            r_state;
   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_rdata;
   logic [ADDR_W-1:0] r_boot_addr;
   logic              r_boot_ready;
   logic              r_boot_done;
   logic              r_cpu_hold;

   logic              w_accept;
   logic              w_last_byte;
   logic              w_cpu_rd;
   logic              w_cpu_wr;

   assign w_accept    = r_boot_ready & mem_if.boot_valid;
   assign w_last_byte = mem_if.boot_last | (r_boot_addr == ADDR_W'(DEPTH - 1));
   assign w_cpu_rd    = (r_state == RUN) & mem_if.mem_re;
   assign w_cpu_wr    = (r_state == RUN) & mem_if.mem_we;

   // RAM contents survive reset, so the array sits outside the reset domain.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_mem[r_boot_addr] <= mem_if.boot_data;
      end else if (w_cpu_wr) begin
         r_mem[mem_if.address_bus] <= mem_if.data_out;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= RUN;
         r_rdata      <= '0;
         r_boot_addr  <= '0;
         r_boot_ready <= 1'b0;
         r_boot_done  <= 1'b0;
         r_cpu_hold   <= 1'b0;
      end else begin
         if (w_cpu_rd) begin
            r_rdata <= r_mem[mem_if.address_bus];
         end
         unique case (r_state)
            RUN: begin
               r_boot_done <= 1'b0;
               // Hold is released one cycle after DONE, giving the CPU a clean restart edge.
               r_cpu_hold  <= mem_if.boot_start;
               if (mem_if.boot_start) begin
                  r_state      <= BOOT;
                  r_boot_addr  <= '0;
                  r_boot_ready <= 1'b1;
               end
            end
            BOOT: begin
               if (w_accept) begin
                  r_boot_addr <= r_boot_addr + ADDR_W'(1);
                  if (w_last_byte) begin
                     r_state      <= DONE;
                     r_boot_ready <= 1'b0;
                     r_boot_done  <= 1'b1;
                  end
               end
            end
            DONE: begin
               r_state     <= RUN;
               r_boot_done <= 1'b0;
            end
            default: begin
               r_state      <= RUN;
               r_boot_ready <= 1'b0;
               r_boot_done  <= 1'b0;
            end
         endcase
      end
   end

   assign mem_if.data_bus   = r_rdata;
   assign mem_if.instr_bus  = r_rdata;
   assign mem_if.boot_ready = r_boot_ready;
   assign mem_if.boot_addr  = r_boot_addr;
   assign mem_if.boot_done  = r_boot_done;
   assign mem_if.cpu_hold   = r_cpu_hold;

endmodule

// File: tb/tb_ahmes_mem_ctrl.sv
// Scoreboard bench for ahmes_mem_ctrl: a behavioural memory/loader model queues the
// expected outputs for every cycle and a negedge monitor pops and compares them.
module tb_ahmes_mem_ctrl;
   localparam int AW    = 8;
   localparam int DW    = 8;
   localparam int DEPTH = 256;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   ahmes_mem_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus_if ();

   ahmes_mem_ctrl #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
      .clk    (clk),
      .reset  (reset),
      .mem_if (bus_if)
   );

   typedef enum {S_DATA, S_INSTR, S_ADDR, S_READY, S_DONE, S_HOLD} sig_e;
   typedef struct {
      int unsigned cyc;
      sig_e        sig;
      logic [7:0]  val;
   } exp_t;

   exp_t        exp_q[$];
   int unsigned cyc = 0;
   int          errors = 0;
   int          checks = 0;
   bit          fin_req = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference model: RAM image, last read value, loader pointer and load phase.
   logic [7:0] m_mem [DEPTH];
   logic [7:0] m_rd   = '0;
   logic [7:0] m_addr = '0;
   bit         m_loading = 1'b0;
   bit         m_done    = 1'b0;
   bit         m_hold    = 1'b0;
   logic [7:0] bq[$];

   function automatic void push_all(input int unsigned stamp);
      exp_q.push_back('{stamp, S_DATA,  m_rd});
      exp_q.push_back('{stamp, S_INSTR, m_rd});
      exp_q.push_back('{stamp, S_ADDR,  m_addr});
      exp_q.push_back('{stamp, S_READY, {7'd0, m_loading}});
      exp_q.push_back('{stamp, S_DONE,  {7'd0, m_done}});
      exp_q.push_back('{stamp, S_HOLD,  {7'd0, m_hold}});
   endfunction

   always @(negedge clk) begin
      exp_t       e;
      logic [7:0] act;
      while (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
         e = exp_q.pop_front();
         case (e.sig)
            S_DATA:  act = bus_if.data_bus;
            S_INSTR: act = bus_if.instr_bus;
            S_ADDR:  act = bus_if.boot_addr;
            S_READY: act = {7'd0, bus_if.boot_ready};
            S_DONE:  act = {7'd0, bus_if.boot_done};
            default: act = {7'd0, bus_if.cpu_hold};
         endcase
         checks++;
         if (e.cyc != cyc || act !== e.val) begin
            errors++;
            $display("FAIL %s cyc=%0d (stamp %0d): got %h expected %h",
                     e.sig.name(), cyc, e.cyc, act, e.val);
         end
      end
      if (fin_req) begin
         checks++;
         if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover: got %0d pending expectations, expected 0", exp_q.size());
         end
         $display("Result: errors=%0d of %0d checks", errors, checks);
         $finish;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached before finish");
      $fatal(1, "watchdog expired");
   end

   task automatic zero_inputs();
      bus_if.address_bus = '0;
      bus_if.data_out    = '0;
      bus_if.mem_re      = 1'b0;
      bus_if.mem_we      = 1'b0;
      bus_if.boot_start  = 1'b0;
      bus_if.boot_valid  = 1'b0;
      bus_if.boot_data   = '0;
      bus_if.boot_last   = 1'b0;
   endtask

   // Apply the current inputs for one edge, advancing the model by the same edge.
   task automatic cycle();
      bit prev_done = m_done;
      m_done = 1'b0;
      if (m_loading) begin
         if (bus_if.boot_valid) begin
            m_mem[m_addr] = bus_if.boot_data;
            if (bus_if.boot_last || m_addr == 8'hFF) begin
               m_loading = 1'b0;
               m_done    = 1'b1;
            end
            m_addr = m_addr + 8'd1;
         end
      end else if (!prev_done) begin
         if (bus_if.mem_re) m_rd = m_mem[bus_if.address_bus];
         if (bus_if.mem_we) m_mem[bus_if.address_bus] = bus_if.data_out;
         if (bus_if.boot_start) begin
            m_loading = 1'b1;
            m_addr    = '0;
         end
      end
      m_hold = m_loading || m_done || prev_done;
      push_all(cyc + 1);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      zero_inputs();
      @(negedge clk);
      #1;
      reset     = 1'b0;
      m_loading = 1'b0;
      m_done    = 1'b0;
      m_hold    = 1'b0;
      m_rd      = '0;
      m_addr    = '0;
      push_all(cyc + 1);
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   task automatic cpu(input bit re, input bit we, input logic [7:0] a, input logic [7:0] d);
      zero_inputs();
      bus_if.mem_re      = re;
      bus_if.mem_we      = we;
      bus_if.address_bus = a;
      bus_if.data_out    = d;
      cycle();
   endtask

   task automatic idle(input int n);
      zero_inputs();
      repeat (n) cycle();
   endtask

   task automatic boot_load(input bit gaps, input bit use_last);
      int unsigned idx = 0;
      zero_inputs();
      bus_if.boot_start = 1'b1;
      cycle();
      while (m_loading && idx < bq.size()) begin
         bus_if.boot_valid  = !gaps || ($urandom_range(3) != 0);
         bus_if.boot_data   = bq[idx];
         bus_if.boot_last   = bus_if.boot_valid ? (use_last && idx == bq.size() - 1)
                                                : 1'($urandom);
         bus_if.boot_start  = 1'($urandom);
         bus_if.mem_re      = 1'($urandom);
         bus_if.mem_we      = 1'($urandom);
         bus_if.address_bus = 8'($urandom);
         bus_if.data_out    = 8'($urandom);
         cycle();
         if (bus_if.boot_valid) idx++;
      end
      zero_inputs();
   endtask

   initial begin
      zero_inputs();
      do_reset();

      for (int i = 0; i < DEPTH; i++)
         cpu(1'b0, 1'b1, i[7:0], (i == 0) ? 8'hA5 : 8'($urandom));
      do_reset();
      cpu(1'b1, 1'b0, 8'h00, 8'h00);
      idle(1);

      cpu(1'b0, 1'b1, 8'h10, 8'h3C);
      cpu(1'b1, 1'b0, 8'h10, 8'h00);
      idle(3);

      cpu(1'b0, 1'b1, 8'h20, 8'h11);
      cpu(1'b1, 1'b1, 8'h20, 8'h22);
      cpu(1'b1, 1'b0, 8'h20, 8'h00);
      idle(1);

      repeat (200)
         cpu(1'($urandom), 1'($urandom),
             ($urandom_range(1) != 0) ? 8'($urandom_range(15)) : 8'($urandom), 8'($urandom));
      idle(1);

      bq = '{8'h20, 8'h80, 8'hF0};
      boot_load(1'b0, 1'b1);
      idle(3);
      for (int i = 0; i < 4; i++) cpu(1'b1, 1'b0, i[7:0], 8'h00);
      idle(1);

      bq.delete();
      for (int i = 0; i < DEPTH; i++) bq.push_back(8'($urandom));
      boot_load(1'b1, 1'b0);
      idle(2);
      bq = '{8'h5A, 8'hC3};
      boot_load(1'b1, 1'b1);
      idle(2);
      for (int i = 0; i < DEPTH; i++) cpu(1'b1, 1'b0, i[7:0], 8'h00);
      idle(1);

      bq = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
      boot_load(1'b0, 1'b0);
      do_reset();
      for (int i = 0; i < 4; i++) cpu(1'b1, 1'b0, i[7:0], 8'h00);
      idle(2);

      fin_req = 1'b1;
      repeat (4) @(posedge clk);
   end

endmodule
